cdb_arbiter: RTL

//  Schedules the single common data bus (CDB) among result producers: three ALU reservation

---
 rtl/cdb_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the registered common data bus.
// Optional mispredict squash port enabled by defining CDB_FLUSH_EN.
module cdb_arbiter #(
   parameter int N_REQ      = 4,
   parameter int TAG_WIDTH  = 3,
   parameter int DATA_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*TAG_WIDTH-1:0]  req_tag,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
`ifdef CDB_FLUSH_EN
   input  logic                        flush,
`endif
   output logic [N_REQ-1:0]            gnt,
   output logic                        cdb_valid,
   output logic [TAG_WIDTH-1:0]        cdb_tag,
   output logic [DATA_WIDTH-1:0]       cdb_data
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         gnt_idx;
   logic [PW-1:0]         nxt_ptr;
   logic                  any_gnt;
   logic                  kill;
   logic [TAG_WIDTH-1:0]  sel_tag;
   logic [DATA_WIDTH-1:0] sel_data;

`ifdef CDB_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   // Circular scan from rr_ptr; first pending requester wins the bus.
   always_comb begin
      int idx;
      gnt      = '0;
      gnt_idx  = '0;
      any_gnt  = 1'b0;
      sel_tag  = '0;
      sel_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ)
            idx = idx - N_REQ;
         if (!any_gnt && req[idx] && rst_n && !kill) begin
            any_gnt  = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
            sel_tag  = req_tag[idx*TAG_WIDTH +: TAG_WIDTH];
            sel_data = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Winner's successor becomes top priority, wrapping at the last index.
   always_comb begin
      if (gnt_idx == PW'(N_REQ - 1))
         nxt_ptr = '0;
      else
         nxt_ptr = gnt_idx + 1'b1;
   end

   // Register the granted result onto the CDB; hold tag/data when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         rr_ptr    <= '0;
      end else if (kill) begin
         cdb_valid <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         cdb_valid <= any_gnt;
         if (any_gnt) begin
            cdb_tag  <= sel_tag;
            cdb_data <= sel_data;
            rr_ptr   <= nxt_ptr;
         end
      end
   end

endmodule
